// File: rtl/bp_be_dcache_lce_resp_sched_if.sv
// bp_be_dcache_lce_resp_sched_if: hi/lo producer valid-yumi ports and the registered lce_resp network port
interface bp_be_dcache_lce_resp_sched_if #(parameter int resp_width_p = 64);
  logic [resp_width_p-1:0] hi_resp_i;
  logic                    hi_v_i;
  logic                    hi_yumi_o;
  logic [resp_width_p-1:0] lo_resp_i;
  logic                    lo_v_i;
  logic                    lo_yumi_o;
  logic [resp_width_p-1:0] resp_o;
  logic                    resp_v_o;
  logic                    resp_ready_i;
  modport slave (
    input  hi_resp_i, hi_v_i, lo_resp_i, lo_v_i, resp_ready_i,
    output hi_yumi_o, lo_yumi_o, resp_o, resp_v_o
  );
  modport master (
    output hi_resp_i, hi_v_i, lo_resp_i, lo_v_i, resp_ready_i,
    input  hi_yumi_o, lo_yumi_o, resp_o, resp_v_o
  );
endinterface

// File: rtl/bp_be_dcache_lce_resp_sched.sv
// bp_be_dcache_lce_resp_sched: fixed-priority hi/lo arbiter with starvation bound feeding a one-entry lce_resp output register
module bp_be_dcache_lce_resp_sched #(
  parameter int resp_width_p   = 64,
  parameter int starve_limit_p = 4
) (
  input logic clk_i,
  input logic reset_n_i,
  bp_be_dcache_lce_resp_sched_if.slave io
);
  localparam int cw = $clog2(starve_limit_p + 1);
  localparam logic [cw-1:0] cnt_max = cw'(starve_limit_p);
  typedef enum logic {EMPTY, FULL} state_e;
  state_e                  r_state, w_state_nxt;
  logic [resp_width_p-1:0] r_resp;
  logic [cw-1:0]           r_cnt, w_cnt_nxt;
  logic                    w_load_en, w_pick_hi, w_pick_lo, w_hi_yumi, w_lo_yumi, w_grant;
  always_comb begin
    w_load_en   = (r_state == EMPTY) | io.resp_ready_i;
    w_pick_hi   = io.hi_v_i & ~(io.lo_v_i & (r_cnt == cnt_max));
    w_pick_lo   = io.lo_v_i & ~w_pick_hi;
    w_hi_yumi   = reset_n_i & w_load_en & w_pick_hi;
    w_lo_yumi   = reset_n_i & w_load_en & w_pick_lo;
    w_grant     = w_hi_yumi | w_lo_yumi;
    w_state_nxt = ~w_load_en ? r_state : w_grant ? FULL : EMPTY;
    // count only advances on a load, so a stalled network never moves the bound
    w_cnt_nxt   = ~w_load_en ? r_cnt
                : (~io.lo_v_i | w_lo_yumi) ? '0
                : (w_hi_yumi & (r_cnt != cnt_max)) ? r_cnt + 1'b1
                : r_cnt;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= EMPTY;
      r_resp  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_grant) r_resp <= w_hi_yumi ? io.hi_resp_i : io.lo_resp_i;
    end
  end
  assign io.hi_yumi_o = w_hi_yumi;
  assign io.lo_yumi_o = w_lo_yumi;
  assign io.resp_o    = r_resp;
  assign io.resp_v_o  = (r_state == FULL);
endmodule
